// File: rtl/multiplier_controller.sv
// Sequencing FSM for a shift-add sequential multiplier datapath, one multiplier bit per iteration, LSB first.
// Optional MULT_ZERO_SKIP_EN: a zero multiplier goes straight from the first CHECK to DONE.
module multiplier_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mr,
  output logic             busy,
  output logic             done,
  output logic             mdld,
  output logic             mrld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;
  logic             zero_skip;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (cnt_q == '0) && (mr == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter. The datapath multiplier register is never shifted, so cnt selects the bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (zero_skip)      state_d = DONE;
        else if (mr[cnt_q]) state_d = ADD;
        else                state_d = SHIFT;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from the registered state only.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mdld    = 1'b0;
    mrld    = 1'b0;
    rsclear = 1'b0;
    rsload  = 1'b0;
    rsshr   = 1'b0;
    case (state_q)
      LOAD: begin
        busy    = 1'b1;
        mdld    = 1'b1;
        mrld    = 1'b1;
        rsclear = 1'b1;
      end
      CHECK: busy = 1'b1;
      ADD: begin
        busy   = 1'b1;
        rsload = 1'b1;
      end
      SHIFT: begin
        busy  = 1'b1;
        rsshr = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multiplier_controller.sv
// Bench for multiplier_controller: a behavioural shift-add datapath, directed and random runs,
// with latency, product and strobe pattern predicted from operand values.
module tb_multiplier_controller;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] mr;
  logic         busy, done, mdld, mrld, rsclear, rsload, rsshr;
  logic [2:0]   state_dbg;

  logic [W-1:0] md_in, mr_in;
  logic [W-1:0] md_q;
  logic [2*W:0] rs_q;

  int tests = 0;
  int fails = 0;

  multiplier_controller #(.WIDTH(W), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mr        (mr),
    .busy      (busy),
    .done      (done),
    .mdld      (mdld),
    .mrld      (mrld),
    .rsclear   (rsclear),
    .rsload    (rsload),
    .rsshr     (rsshr),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath the controller drives: sum accumulates in the upper half and shifts right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_q <= '0;
      mr   <= '0;
      rs_q <= '0;
    end else begin
      if (mdld) md_q <= md_in;
      if (mrld) mr   <= mr_in;
      if (rsclear)     rs_q <= '0;
      else if (rsload) rs_q[2*W:W] <= rs_q[2*W:W] + {1'b0, md_q};
      else if (rsshr)  rs_q <= rs_q >> 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {6'd0, busy, done, mdld, mrld, rsclear, rsload, rsshr, state_dbg};
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (b == 0) return 3;
`endif
    return 2 * W + 2 + $countones(b);
  endfunction

  function automatic int exp_shifts(input logic [W-1:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (b == 0) return 0;
`endif
    return W;
  endfunction

  // Driver + monitor for one multiplication. Enter and leave at a falling edge with the FSM in IDLE.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input int pulse_at);
    int done_cyc, shifts, mask, excl;
    logic [15:0] prod;
    md_in = a;
    mr_in = b;
    start = 1'b1;
    done_cyc = -1;
    shifts = 0;
    mask = 0;
    excl = 0;
    prod = '0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (!hold) start = (pulse_at != 0 && cyc == pulse_at);
      if (cyc == 1) begin
        check("load_state", 16'(state_dbg), 16'd1);
        check("load_strobes", {12'd0, busy, mdld, mrld, rsclear}, 16'hf);
      end
      if (rsload) mask |= (1 << shifts);
      if (rsshr) shifts++;
      if (rsload && rsshr) excl++;
      if (rsclear && cyc != 1) excl++;
      if (done) begin
        done_cyc = cyc;
        prod = 16'(rs_q[2*W-1:0]);
        check("done_state", {12'd0, busy, state_dbg}, 16'hd);
      end
    end
    check($sformatf("latency_%0dx%0d", a, b), 16'(done_cyc), 16'(exp_latency(b)));
    check($sformatf("product_%0dx%0d", a, b), prod, 16'(a * b));
    check("add_iterations", 16'(mask), 16'(b));
    check("shift_count", 16'(shifts), 16'(exp_shifts(b)));
    check("strobe_exclusive", 16'(excl), 16'd0);
    @(negedge clk);
    check("post_done_idle", all_outs(), 16'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 16'(busy), 16'd0);
  endtask

  initial begin
    bit found;
    // Reset held with start high: everything stays at 0.
    rst_n = 1'b0;
    start = 1'b1;
    md_in = 4'd5;
    mr_in = 4'd3;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("release_to_load", 16'(state_dbg), 16'd1);
    start = 1'b0;
    wait_idle();

    run_mult(4'd5, 4'd3, 1'b0, 0);
    run_mult(4'd15, 4'd15, 1'b0, 0);
    run_mult(4'd9, 4'd0, 1'b0, 0);

    // start pulsed mid-run is ignored and never queued.
    run_mult(4'd11, 4'd6, 1'b0, 4);
    @(negedge clk);
    check("no_queued_run", 16'(state_dbg), 16'd0);

    // start held: back-to-back runs, one IDLE cycle between them.
    run_mult(4'd7, 4'd13, 1'b1, 0);
    run_mult(4'd3, 4'd9, 1'b1, 0);
    start = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 0);
    end

    // Asynchronous abort in the middle of an ADD.
    md_in = 4'd15;
    mr_in = 4'd15;
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (state_dbg == 3'd3) found = 1'b1;
    end
    check("reached_add", 16'(found), 16'd1);
    #2 rst_n = 1'b0;
    #1 check("async_abort", all_outs(), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_abort", all_outs(), 16'd0);
    run_mult(4'd6, 4'd7, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
